// File: rtl/sram_1rw1r_array_pkg.sv
// Shared types, limits and helpers for the 1RW/1R SRAM array.
package sram_pkg;

    typedef enum logic {
        INIT,
        READY
    } sram_state_e;

    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 3;

    function automatic int unsigned num_wmasks(input int unsigned dw, input int unsigned gran);
        return dw / gran;
    endfunction

endpackage

// File: rtl/sram_1rw1r_array_if.sv
// Request/response bundle for the 1RW/1R SRAM array; the array side uses the slave modport.
interface sram_1rw1r_array_if
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WMASK_GRAN = 8
);
    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_GRAN);

    logic                  busy;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  collision;

    modport master (
        input  busy, dout0, dout0_valid, dout1, dout1_valid, collision,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output busy, dout0, dout0_valid, dout1, dout1_valid, collision,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

endinterface

// File: rtl/sram_1rw1r_array_rd_pipe.sv
// Read-return delay line carrying {valid, collision, data}; data stages only load on valid so the
// final stage holds the last returned word.
module sram_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic                  coll_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic                  coll_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    coll_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            coll_q  <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= (valid_q << 1) | LATENCY'(valid_i);
            coll_q  <= (coll_q << 1) | LATENCY'(coll_i & valid_i);
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign coll_o  = coll_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_array.sv
// Behavioural 1RW/1R SRAM with byte-masked writes, post-reset zero sweep, read-first collisions and
// configurable read latency.
module sram_1rw1r_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned WMASK_GRAN   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned INIT_ZERO    = 1
) (
    input  logic                 clk0,
    input  logic                 rst0_n,
    sram_1rw1r_array_if.slave    bus
);

    localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_GRAN);

    if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
        $fatal(1, "sram_1rw1r_array: DATA_WIDTH must be a multiple of WMASK_GRAN");
    end
    if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
        $fatal(1, "sram_1rw1r_array: READ_LATENCY out of range");
    end

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  ready, wr0, rd0, rd1, coll;
    logic                  rd0_vld_q, rd1_vld_q, coll_q;
    logic [DATA_WIDTH-1:0] rd0_data_q, rd1_data_q;
    logic                  rd0_coll_unused;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= (INIT_ZERO != 0) ? INIT : READY;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) begin
                state_d = READY;
            end
        end
    end

    assign ready    = (state_q == READY);
    assign bus.busy = ~ready;
    assign wr0      = ready & ~bus.csb0 & ~bus.web0;
    assign rd0      = ready & ~bus.csb0 & bus.web0;
    assign rd1      = ready & ~bus.csb1;
    assign coll     = rd1 & wr0 & (bus.addr0 == bus.addr1);

    // Read data is captured with non-blocking semantics in the same block as the write, so a
    // same-edge write to the read address is not visible: read-first on both ports.
    always_ff @(posedge clk0) begin
        if (state_q == INIT) begin
            mem[sweep_q] <= '0;
        end else if (wr0) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    mem[bus.addr0][i*WMASK_GRAN +: WMASK_GRAN] <= bus.din0[i*WMASK_GRAN +: WMASK_GRAN];
                end
            end
        end
        if (rd0) begin
            rd0_data_q <= mem[bus.addr0];
        end
        if (rd1) begin
            rd1_data_q <= mem[bus.addr1];
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            rd0_vld_q <= rd0;
            rd1_vld_q <= rd1;
            coll_q    <= coll;
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd0_pipe (
        .clk_i   (clk0),
        .rst_ni  (rst0_n),
        .valid_i (rd0_vld_q),
        .coll_i  (1'b0),
        .data_i  (rd0_data_q),
        .valid_o (bus.dout0_valid),
        .coll_o  (rd0_coll_unused),
        .data_o  (bus.dout0)
    );

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd1_pipe (
        .clk_i   (clk0),
        .rst_ni  (rst0_n),
        .valid_i (rd1_vld_q),
        .coll_i  (coll_q),
        .data_i  (rd1_data_q),
        .valid_o (bus.dout1_valid),
        .coll_o  (bus.collision),
        .data_o  (bus.dout1)
    );

endmodule

// File: tb/tb_sram_1rw1r_array.sv
// Three arrays (read latency 1, 2, 3) driven with identical stimulus and checked every cycle against
// a queue-based model of memory contents and read returns.
module tb_sram_1rw1r_array;
    import sram_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 4;
    localparam int unsigned NL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
    logic [31:0]   wmask0 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] din0 = '0;

    logic          busy_w [NL];
    logic          v0_w   [NL];
    logic          v1_w   [NL];
    logic          col_w  [NL];
    logic [DW-1:0] d0_w   [NL];
    logic [DW-1:0] d1_w   [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        sram_1rw1r_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(8)) bus ();
        sram_1rw1r_array #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .WMASK_GRAN   (8),
            .READ_LATENCY (g + 1),
            .INIT_ZERO    (1)
        ) u_dut (
            .clk0   (clk),
            .rst0_n (rst_n),
            .bus    (bus)
        );
        assign bus.csb0   = csb0;
        assign bus.web0   = web0;
        assign bus.wmask0 = wmask0;
        assign bus.addr0  = addr0;
        assign bus.din0   = din0;
        assign bus.csb1   = csb1;
        assign bus.addr1  = addr1;
        assign busy_w[g]  = bus.busy;
        assign v0_w[g]    = bus.dout0_valid;
        assign v1_w[g]    = bus.dout1_valid;
        assign col_w[g]   = bus.collision;
        assign d0_w[g]    = bus.dout0;
        assign d1_w[g]    = bus.dout1;
    end

    typedef struct {
        int          due;
        logic [DW-1:0] d;
        bit          c;
    } rd_t;

    logic [DW-1:0] mem_m [16];
    bit            busy_m;
    int            sweep_m;
    int            cyc;
    rd_t           q0 [NL][$];
    rd_t           q1 [NL][$];
    logic [DW-1:0] dout0_m [NL];
    logic [DW-1:0] dout1_m [NL];
    bit            v0_m [NL];
    bit            v1_m [NL];
    bit            col_m [NL];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("L%0d_busy", l + 1), DW'(busy_w[l]), DW'(busy_m));
            chk($sformatf("L%0d_v0", l + 1), DW'(v0_w[l]), DW'(v0_m[l]));
            chk($sformatf("L%0d_v1", l + 1), DW'(v1_w[l]), DW'(v1_m[l]));
            chk($sformatf("L%0d_coll", l + 1), DW'(col_w[l]), DW'(col_m[l]));
            chk($sformatf("L%0d_dout0", l + 1), d0_w[l], dout0_m[l]);
            chk($sformatf("L%0d_dout1", l + 1), d1_w[l], dout1_m[l]);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] r0, r1;
        bit wr, c;
        rd_t e;
        cyc++;
        if (busy_m) begin
            mem_m[sweep_m] = '0;
            sweep_m++;
            if (sweep_m == 16) busy_m = 1'b0;
        end else begin
            wr = !csb0 && !web0;
            r0 = mem_m[addr0];
            r1 = mem_m[addr1];
            c  = wr && !csb1 && (addr0 == addr1);
            for (int l = 0; l < NL; l++) begin
                if (!csb0 && web0) q0[l].push_back('{cyc + l + 1, r0, 1'b0});
                if (!csb1) q1[l].push_back('{cyc + l + 1, r1, c});
            end
            if (wr) begin
                for (int k = 0; k < 32; k++) begin
                    if (wmask0[k]) mem_m[addr0][k*8 +: 8] = din0[k*8 +: 8];
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            v0_m[l] = 1'b0;
            v1_m[l] = 1'b0;
            col_m[l] = 1'b0;
            if (q0[l].size() > 0 && q0[l][0].due == cyc) begin
                e = q0[l].pop_front();
                v0_m[l] = 1'b1;
                dout0_m[l] = e.d;
            end
            if (q1[l].size() > 0 && q1[l][0].due == cyc) begin
                e = q1[l].pop_front();
                v1_m[l] = 1'b1;
                col_m[l] = e.c;
                dout1_m[l] = e.d;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        repeat (n) tick();
    endtask

    task automatic reset_dut(input int n);
        rst_n = 1'b0;
        busy_m = 1'b1;
        sweep_m = 0;
        for (int l = 0; l < NL; l++) begin
            q0[l].delete();
            q1[l].delete();
            dout0_m[l] = '0; dout1_m[l] = '0;
            v0_m[l] = 1'b0; v1_m[l] = 1'b0; col_m[l] = 1'b0;
        end
        #1;
        compare_all();
        repeat (n) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic sweep_and_count(input string tag);
        int cnt = 0;
        while (busy_w[0] && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(tag, DW'(cnt), DW'(16));
    endtask

    task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
        tick();
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        #1;
        cyc = 0;
        reset_dut(2);
        sweep_and_count("busy_cycles_first");

        // Every address reads zero on both ports after the sweep.
        for (int i = 0; i < 16; i++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(i);
            csb1 = 1'b0; addr1 = AW'(15 - i);
            tick();
        end
        idle(4);

        // Masked write of the low four lanes over a full-mask write.
        write0(4'd3, {32{8'hA5}}, 32'hFFFF_FFFF);
        write0(4'd3, {32{8'h5A}}, 32'h0000_000F);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd3;
        tick();
        idle(4);
        for (int l = 0; l < NL; l++) begin
            chk("masked_rd_p0", d0_w[l], {{28{8'hA5}}, {4{8'h5A}}});
            chk("masked_rd_p1", d1_w[l], {{28{8'hA5}}, {4{8'h5A}}});
        end

        // Back-to-back port 0 reads of distinct words.
        write0(4'd1, rand_word(), '1);
        write0(4'd2, rand_word(), '1);
        for (int a = 1; a <= 3; a++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(a); csb1 = 1'b1;
            tick();
        end
        idle(5);

        // Read-first collision, then a later read sees the write.
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = DW'(1); wmask0 = '1;
        csb1 = 1'b0; addr1 = 4'd5;
        tick();
        idle(4);
        for (int l = 0; l < NL; l++) chk("coll_old_data", d1_w[l], '0);
        csb1 = 1'b0; addr1 = 4'd5;
        tick();
        idle(4);
        for (int l = 0; l < NL; l++) chk("after_coll_data", d1_w[l], DW'(1));

        // Reset mid-sweep restarts the sweep from address 0.
        write0(4'd12, rand_word(), '1);
        idle(1);
        reset_dut(2);
        repeat (9) tick();
        reset_dut(1);
        sweep_and_count("busy_cycles_restart");
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd12; csb1 = 1'b0; addr1 = 4'd12;
        tick();
        idle(4);
        for (int l = 0; l < NL; l++) chk("addr12_zero", d0_w[l], '0);

        // Reads in flight when reset hits are dropped; requests during busy are ignored.
        w = rand_word();
        w[0] = 1'b1;
        write0(4'd7, w, '1);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd7; csb1 = 1'b0; addr1 = 4'd7;
        tick();
        idle(1);
        reset_dut(2);
        csb0 = 1'b0; web0 = 1'b1; csb1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr0 = AW'(i); addr1 = AW'(i);
            tick();
        end
        idle(5);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            csb0 = ($urandom_range(0, 3) == 0);
            web0 = $urandom_range(0, 1);
            wmask0 = $urandom;
            addr0 = AW'($urandom_range(0, 15));
            din0 = rand_word();
            csb1 = ($urandom_range(0, 3) == 0);
            addr1 = ($urandom_range(0, 2) == 0) ? addr0 : AW'($urandom_range(0, 15));
            tick();
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
